stopwatch_lap_ctrl: RTL and testbench
=====================================

# stopwatch_lap_ctrl

Mode controller for the stopwatch datapath, running in the 1 kHz domain between the debounced/single-pulsed buttons and the BCD counter/seven-segment display. It sequences start/stop/clear of the counter and captures lap times into a small circular lap buffer. It recalls stored laps onto the display while the watch is paused. It replaces the ad-hoc run toggle and per-digit lap registers with one FSM that owns the counter enable, the counter clear and the display source.

## Interface
- DEPTH, 4: number of lap entries; power of two, 2..16.
- HOLD_CYCLES, 2000: clk cycles a freshly captured lap stays on the display. Used only with the hold feature.
- clk  in  1  system clock; 1 kHz divided clock.
- reset  in  1  synchronous, active-low reset. While 0, all state and outputs take reset values on the next clk edge.
- ststop_p  in  1  start/stop request; single-cycle pulse.
- lap_p  in  1  lap capture / recall-advance request; single-cycle pulse.
- clear_p  in  1  clear request; single-cycle pulse.
- live_bcd  in  16  live counter digits {d4,d3,d2,d1}, BCD.
- run  out  1  counter enable.
- cnt_clr  out  1  one-cycle synchronous clear to the counter.
- disp_bcd  out  16  digits to display, BCD.
- recall  out  1  high while a stored lap is displayed in RECALL.
- lap_sel  out  $clog2(DEPTH)  index of the lap being recalled; 0 = oldest.
- lap_count  out  $clog2(DEPTH)+1  number of valid laps, 0..DEPTH.

## Operation
- States: IDLE, RUN, PAUSE, RECALL. Reset puts the FSM in IDLE.
- Request priority when pulses coincide: clear_p > ststop_p > lap_p. Only the highest-priority request that is legal in the current state acts; the others are dropped.
- **IDLE** (run=0):
  - ststop_p → RUN.
  - clear_p → pulse cnt_clr and empty the buffer; stay in IDLE.
  - lap_p is ignored.
- **RUN** (run=1):
  - ststop_p → PAUSE.
  - lap_p → write live_bcd to the buffer.
    - If lap_count < DEPTH: append, and lap_count increments.
    - If full: overwrite the oldest entry; lap_count stays at DEPTH and the read origin advances by one.
  - clear_p is ignored.
- **PAUSE** (run=0):
  - ststop_p → RUN.
  - clear_p → IDLE, pulse cnt_clr, empty the buffer.
  - lap_p with lap_count > 0 → RECALL with lap_sel=0.
  - lap_p with lap_count = 0 is ignored.
- **RECALL** (run=0, recall=1):
  - lap_p → lap_sel+1. If lap_sel = lap_count−1, go to PAUSE instead.
  - ststop_p → RUN; recall drops.
  - clear_p → IDLE, pulse cnt_clr, empty the buffer.
- Display source:
  - RECALL: buffer entry lap_sel, counted from the oldest.
  - All other states: live_bcd, except while a hold is active (see Configuration).
- Buffer:
  - Write pointer and read origin are modulo-DEPTH and wrap naturally.
  - Entries are not zeroed on empty; only lap_count and the pointers reset.

## Timing
- All outputs are registered.
- run changes on the edge after the cycle in which ststop_p is sampled high.
- cnt_clr is high for exactly one cycle, the cycle after clear_p is sampled. The FSM is in IDLE in that same cycle.
- Lap capture samples live_bcd on the same edge that samples lap_p. lap_count updates on that edge.
- disp_bcd has 1 cycle latency from live_bcd, from a state change, and from a lap_sel change.
- Back-to-back pulses on consecutive cycles are each honoured.
- Reset values: run=0, cnt_clr=0, disp_bcd=16'h0000, recall=0, lap_sel=0, lap_count=0, hold counter=0.
- Reset mid-operation (reset=0 on any edge) discards the pending request and empties the buffer.

## Configuration
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Each capture in RUN loads a hold counter with HOLD_CYCLES.
  - While the counter is non-zero in RUN, disp_bcd shows the just-captured lap; it decrements each cycle and the display returns to live_bcd when it reaches 0.
  - A new capture during a hold reloads the counter and shows the new lap.
  - Leaving RUN clears the hold.
- Undefined: no hold counter; in RUN, disp_bcd always follows live_bcd.

## Test plan
- Reset, then ststop_p → run=1 one cycle later. Second ststop_p → run=0 and state PAUSE. clear_p → cnt_clr high for 1 cycle, lap_count=0.
- In RUN, lap_p with live_bcd = 0x0012, 0x0034, 0x0056 → lap_count=3. Pause, then lap_p ×4 → disp_bcd shows 0x0012, 0x0034, 0x0056 with recall=1, then recall=0 in PAUSE.
- DEPTH=4 with six captures 0x0001..0x0006 → lap_count=4. Recall order 0x0003, 0x0004, 0x0005, 0x0006 (wrap-around).
- Same-cycle clear_p + ststop_p in PAUSE → IDLE with cnt_clr pulse and run stays 0. Same-cycle ststop_p + lap_p in RUN → PAUSE and no capture.
- reset=0 asserted in RECALL with lap_sel=2 → next cycle all outputs at reset values. Subsequent lap_p in IDLE is ignored.
- With STOPWATCH_LAP_HOLD_EN and HOLD_CYCLES=5, capture 0x0099 in RUN → disp_bcd=0x0099 for 5 cycles, then tracks live_bcd. Without the macro, disp_bcd tracks live_bcd throughout.

Source files
------------

// File: rtl/stopwatch_lap_ctrl_if.sv
// stopwatch_lap_ctrl_if
//   Bundles the button requests, live counter digits and the controller
//   outputs of stopwatch_lap_ctrl.
//   master : drives ststop_p, lap_p, clear_p, live_bcd; observes outputs.
//   slave  : the controller; observes requests, drives run, cnt_clr,
//            disp_bcd, recall, lap_sel, lap_count.
interface stopwatch_lap_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          ststop_p;
  logic          lap_p;
  logic          clear_p;
  logic [15:0]   live_bcd;
  logic          run;
  logic          cnt_clr;
  logic [15:0]   disp_bcd;
  logic          recall;
  logic [AW-1:0] lap_sel;
  logic [AW:0]   lap_count;

  modport master (
    output ststop_p, lap_p, clear_p, live_bcd,
    input  run, cnt_clr, disp_bcd, recall, lap_sel, lap_count
  );

  modport slave (
    input  ststop_p, lap_p, clear_p, live_bcd,
    output run, cnt_clr, disp_bcd, recall, lap_sel, lap_count
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl
//   Mode controller for the stopwatch: sequences start/stop/clear of the BCD
//   counter, captures lap times into a circular buffer of DEPTH entries and
//   recalls them onto the display while paused.
// Ports:
//   clk    : 1 kHz clock
//   reset  : synchronous, active-low
//   bus    : stopwatch_lap_ctrl_if.slave (requests in, run/cnt_clr/disp_bcd/
//            recall/lap_sel/lap_count out, all registered)
// Parameters: DEPTH (power of two, 2..16), HOLD_CYCLES (hold feature only).
// Optional feature macro: STOPWATCH_LAP_HOLD_EN -- freshly captured lap is held
//   on the display for HOLD_CYCLES cycles while running.
module stopwatch_lap_ctrl #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_lap_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (HOLD_CYCLES < 1)) begin : g_bad_param
      $error("stopwatch_lap_ctrl: illegal DEPTH or HOLD_CYCLES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RECALL} state_t;

  state_t        state_q, state_n;
  logic          run_q, cnt_clr_q, recall_q;
  logic [15:0]   disp_q, disp_n;
  logic [AW-1:0] sel_q, sel_n;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr_q, rd_org_q, rd_idx;
  logic [15:0]   mem [DEPTH];
  logic          do_clear, do_capture;
  logic          full, last;

  assign full   = (count_q == CW'(DEPTH));
  assign last   = ((CW'(sel_q) + CW'(1)) == count_q);
  // Entries are addressed relative to the oldest; the AW-bit add wraps.
  assign rd_idx = rd_org_q + sel_q;

  // Single-request decode: clear > start/stop > lap, illegal ones dropped.
  always_comb begin
    state_n    = state_q;
    sel_n      = sel_q;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_p)       do_clear = 1'b1;
        else if (bus.ststop_p) state_n  = RUN;
      end
      RUN: begin
        if (bus.ststop_p)   state_n    = PAUSE;
        else if (bus.lap_p) do_capture = 1'b1;
      end
      PAUSE: begin
        if (bus.clear_p) begin
          state_n  = IDLE;
          do_clear = 1'b1;
        end else if (bus.ststop_p) begin
          state_n = RUN;
        end else if (bus.lap_p && (count_q != '0)) begin
          state_n = RECALL;
          sel_n   = '0;
        end
      end
      RECALL: begin
        if (bus.clear_p) begin
          state_n  = IDLE;
          do_clear = 1'b1;
        end else if (bus.ststop_p) begin
          state_n = RUN;
        end else if (bus.lap_p) begin
          if (last) state_n = PAUSE;
          else      sel_n   = sel_q + 1'b1;
        end
      end
    endcase
    if (state_n != RECALL) sel_n = '0;
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_cnt_q;
  logic [15:0]   hold_val_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt_q <= '0;
      hold_val_q <= '0;
    end else if (do_capture) begin
      hold_cnt_q <= HW'(HOLD_CYCLES);
      hold_val_q <= bus.live_bcd;
    end else if (state_n != RUN) begin
      hold_cnt_q <= '0;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_q <= hold_cnt_q - 1'b1;
    end
  end
`endif

  // Display is driven from the current (registered) state, giving one cycle
  // of latency from both state and lap_sel changes.
  always_comb begin
    disp_n = bus.live_bcd;
    if (state_q == RECALL) disp_n = mem[rd_idx];
`ifdef STOPWATCH_LAP_HOLD_EN
    else if ((state_q == RUN) && (hold_cnt_q != '0)) disp_n = hold_val_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
      recall_q  <= 1'b0;
      disp_q    <= '0;
      sel_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_org_q  <= '0;
    end else begin
      state_q   <= state_n;
      run_q     <= (state_n == RUN);
      recall_q  <= (state_n == RECALL);
      cnt_clr_q <= do_clear;
      disp_q    <= disp_n;
      sel_q     <= sel_n;
      if (do_clear) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_org_q <= '0;
      end else if (do_capture) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (full) rd_org_q <= rd_org_q + 1'b1;
        else      count_q  <= count_q + 1'b1;
      end
    end
  end

  // Lap storage has no reset; emptying only resets count and pointers.
  always_ff @(posedge clk) begin
    if (reset && do_capture) mem[wr_ptr_q] <= bus.live_bcd;
  end

  assign bus.run       = run_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.recall    = recall_q;
  assign bus.disp_bcd  = disp_q;
  assign bus.lap_sel   = sel_q;
  assign bus.lap_count = count_q;
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl
//   Scoreboard bench: the driver applies one request vector per cycle and
//   pushes the reference model's expected outputs; the monitor pops and
//   compares after each clock edge. Model uses a lap queue and a mode name.
module tb_stopwatch_lap_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int HOLD  = 5;

  typedef struct {
    logic [15:0]   disp;
    bit            run;
    bit            clr;
    bit            recall;
    logic [AW-1:0] sel;
    logic [AW:0]   cnt;
  } exp_t;

  logic clk;
  logic reset;

  stopwatch_lap_ctrl_if #(.DEPTH(DEPTH)) bus ();

  stopwatch_lap_ctrl #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;

  // Reference model state
  string       mode = "IDLE";
  logic [15:0] laps[$];
  int          sel = 0;
  int          hold_left = 0;
  logic [15:0] hold_val = '0;

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic apply(input bit rst_n, input bit ss, input bit lp,
                       input bit cl, input logic [15:0] live);
    exp_t e;
    bit   captured;
    @(negedge clk);
    reset        = rst_n;
    bus.ststop_p = ss;
    bus.lap_p    = lp;
    bus.clear_p  = cl;
    bus.live_bcd = live;
    captured     = 1'b0;
    e.clr        = 1'b0;
    if (!rst_n) begin
      mode = "IDLE";
      laps.delete();
      sel = 0;
      hold_left = 0;
      e.disp = 16'h0000;
    end else begin
      // Display reflects the mode held before this edge.
      if (mode == "RECALL") e.disp = laps[sel];
      else if (mode == "RUN" && hold_left > 0) e.disp = hold_val;
      else e.disp = live;
      case (mode)
        "IDLE": begin
          if (cl) begin e.clr = 1'b1; laps.delete(); end
          else if (ss) mode = "RUN";
        end
        "RUN": begin
          if (ss) mode = "PAUSE";
          else if (lp) begin
            if (laps.size() == DEPTH) void'(laps.pop_front());
            laps.push_back(live);
            captured = 1'b1;
          end
        end
        "PAUSE": begin
          if (cl) begin mode = "IDLE"; e.clr = 1'b1; laps.delete(); end
          else if (ss) mode = "RUN";
          else if (lp && laps.size() > 0) begin mode = "RECALL"; sel = 0; end
        end
        default: begin // RECALL
          if (cl) begin mode = "IDLE"; e.clr = 1'b1; laps.delete(); end
          else if (ss) mode = "RUN";
          else if (lp) begin
            if (sel == laps.size() - 1) mode = "PAUSE";
            else sel++;
          end
        end
      endcase
`ifdef STOPWATCH_LAP_HOLD_EN
      if (captured) begin hold_left = HOLD; hold_val = live; end
      else if (mode != "RUN") hold_left = 0;
      else if (hold_left > 0) hold_left--;
`endif
    end
    if (mode != "RECALL") sel = 0;
    e.run    = (mode == "RUN");
    e.recall = (mode == "RECALL");
    e.sel    = AW'(sel);
    e.cnt    = (AW+1)'(laps.size());
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, rand_bcd());
  endtask

  // Monitor: outputs are valid every cycle; compare one expectation per edge.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        bad = (bus.disp_bcd !== e.disp) || (bus.run !== e.run) ||
              (bus.cnt_clr !== e.clr) || (bus.recall !== e.recall) ||
              (bus.lap_count !== e.cnt) ||
              ((e.recall || !reset) && (bus.lap_sel !== e.sel));
        if (bad) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got run=%0b clr=%0b disp=%h recall=%0b sel=%0d cnt=%0d, want run=%0b clr=%0b disp=%h recall=%0b sel=%0d cnt=%0d",
                   vectors, $time, bus.run, bus.cnt_clr, bus.disp_bcd, bus.recall,
                   bus.lap_sel, bus.lap_count, e.run, e.clr, e.disp, e.recall,
                   e.sel, e.cnt);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.ststop_p = 1'b0;
    bus.lap_p    = 1'b0;
    bus.clear_p  = 1'b0;
    bus.live_bcd = '0;

    apply(0, 0, 0, 0, 16'h1234);
    apply(0, 0, 0, 0, 16'h0000);
    // start / stop / clear
    apply(1, 1, 0, 0, 16'h0000);
    idle(2);
    apply(1, 1, 0, 0, 16'h0003);
    apply(1, 0, 0, 1, 16'h0003);
    idle(1);
    // three captures then recall all
    apply(1, 1, 0, 0, 16'h0000);
    apply(1, 0, 1, 0, 16'h0012);
    idle(1);
    apply(1, 0, 1, 0, 16'h0034);
    apply(1, 0, 1, 0, 16'h0056);
    apply(1, 1, 0, 0, 16'h0057);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 1, 0, 16'h0057);
      idle(1);
    end
    apply(1, 0, 0, 1, 16'h0057);
    // wrap-around: six captures into four entries
    apply(1, 1, 0, 0, 16'h0000);
    for (int i = 1; i <= 6; i++) apply(1, 0, 1, 0, 16'(i));
    apply(1, 1, 0, 0, 16'h0007);
    for (int i = 0; i < 5; i++) apply(1, 0, 1, 0, 16'h0007);
    // coincident requests
    apply(1, 1, 0, 1, 16'h0007);
    idle(1);
    apply(1, 1, 0, 0, 16'h0000);
    apply(1, 1, 1, 0, 16'h0001);
    idle(1);
    // hold window, then reset while recalling lap_sel=2
    apply(1, 1, 0, 0, 16'h0000);
    apply(1, 0, 1, 0, 16'h0099);
    idle(8);
    apply(1, 0, 1, 0, 16'h0100);
    apply(1, 0, 1, 0, 16'h0101);
    apply(1, 1, 0, 0, 16'h0102);
    for (int i = 0; i < 3; i++) apply(1, 0, 1, 0, 16'h0102);
    apply(0, 0, 1, 0, 16'h0102);
    apply(1, 0, 1, 0, 16'h0200);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rn, ss, lp, cl;
      rn = ($urandom_range(0, 199) != 0);
      ss = ($urandom_range(0, 7) == 0);
      lp = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 19) == 0);
      apply(rn, ss, lp, cl, rand_bcd());
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
